// File: rtl/audio_out_dac_pkg.sv
// Shared definitions for the audio output stage.
//   mode_e     : output modulator selection (PWM or first-order sigma-delta)
//   *_W        : datapath widths for sample, gain and scaled level
//   PWM_PERIOD : PWM frame length in clock cycles
//   gain_step  : moves the effective gain one step toward its target
package audio_pkg;

  typedef enum logic {
    MODE_PWM = 1'b0,
    MODE_SD  = 1'b1
  } mode_e;

  localparam int SAMPLE_W   = 4;
  localparam int GAIN_W     = 4;
  localparam int LEVEL_W    = 8;
  localparam int PWM_PERIOD = 255;

  // One step per call so a retarget mid-ramp never jumps.
  function automatic logic [GAIN_W-1:0] gain_step(input logic [GAIN_W-1:0] cur,
                                                  input logic [GAIN_W-1:0] tgt);
    logic [GAIN_W-1:0] nxt;
    nxt = cur;
    if (cur < tgt) begin
      nxt = cur + GAIN_W'(1);
    end else if (cur > tgt) begin
      nxt = cur - GAIN_W'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/audio_out_dac_if.sv
// Signal bundle between the sound generator side and the audio output stage.
//   sample     : 4-bit mixed sample, valid from the cycle after sample_ena
//   volume     : target gain 0..15
//   mute       : 1 ramps the gain to 0
//   mode       : 0 = PWM, 1 = sigma-delta
//   sample_ena : one-cycle sample-rate strobe
//   level      : current scaled level
//   audio_out  : registered 1-bit modulated output
// master = generator/controller side, slave = audio_out_dac.
interface audio_out_dac_if;
  import audio_pkg::*;

  logic [SAMPLE_W-1:0] sample;
  logic [GAIN_W-1:0]   volume;
  logic                mute;
  logic                mode;
  logic                sample_ena;
  logic [LEVEL_W-1:0]  level;
  logic                audio_out;

  modport master (
    output sample, volume, mute, mode,
    input  sample_ena, level, audio_out
  );

  modport slave (
    input  sample, volume, mute, mode,
    output sample_ena, level, audio_out
  );

endinterface

// File: rtl/audio_out_dac_sample_strobe_gen.sv
// Fractional clock divider producing a one-cycle strobe whose average rate
// is SAMPLE_RATE strobes per CLK_FREQ clock cycles.
//   clock      : system clock
//   reset      : synchronous, active-high
//   sample_ena : registered strobe, never high on two consecutive cycles
//                while SAMPLE_RATE < CLK_FREQ/2
module sample_strobe_gen #(
  parameter int CLK_FREQ    = 25175000,
  parameter int SAMPLE_RATE = 16384
) (
  input  logic clock,
  input  logic reset,
  output logic sample_ena
);

  localparam int ACC_W = $clog2(CLK_FREQ) + 1;
  localparam logic [ACC_W:0] RATE_C = (ACC_W+1)'(SAMPLE_RATE);
  localparam logic [ACC_W:0] FREQ_C = (ACC_W+1)'(CLK_FREQ);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ena_q, ena_d;
  logic [ACC_W:0]   sum;
  logic [ACC_W:0]   wrapped;

  always_comb begin
    sum     = {1'b0, acc_q} + RATE_C;
    wrapped = sum - FREQ_C;
    acc_d   = sum[ACC_W-1:0];
    ena_d   = 1'b0;
    if (sum >= FREQ_C) begin
      acc_d = wrapped[ACC_W-1:0];
      ena_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q <= '0;
      ena_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ena_q <= ena_d;
    end
  end

  assign sample_ena = ena_q;

endmodule

// File: rtl/audio_out_dac.sv
// Audio output stage: paces the sound generator with sample_ena, captures its
// sample, applies a ramped volume gain and drives a 1-bit PWM or sigma-delta
// output for an external RC filter.
//   clock, reset : system clock, synchronous active-high reset
//   bus (slave)  : sample/volume/mute/mode in, sample_ena/level/audio_out out
module audio_out_dac
  import audio_pkg::*;
#(
  parameter int CLK_FREQ    = 25175000,
  parameter int SAMPLE_RATE = 16384
) (
  input  logic            clock,
  input  logic            reset,
  audio_out_dac_if.slave  bus
);

  logic                ena;
  logic                ena_d_q, ena_d_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic [GAIN_W-1:0]   vol_eff_q, vol_eff_d;
  logic [LEVEL_W-1:0]  level_q, level_d;
  logic [LEVEL_W-1:0]  pwm_cnt_q, pwm_cnt_d;
  logic [LEVEL_W-1:0]  pwm_cmp_q, pwm_cmp_d;
  logic [LEVEL_W-1:0]  sd_acc_q, sd_acc_d;
  logic                audio_q, audio_d;
  logic [GAIN_W-1:0]   target;
  logic [LEVEL_W:0]    sd_sum;
  logic                pwm_bit;

  sample_strobe_gen #(
    .CLK_FREQ    (CLK_FREQ),
    .SAMPLE_RATE (SAMPLE_RATE)
  ) u_strobe (
    .clock      (clock),
    .reset      (reset),
    .sample_ena (ena)
  );

  always_comb begin
    ena_d_d   = ena;
    sample_d  = sample_q;
    vol_eff_d = vol_eff_q;
    pwm_cmp_d = pwm_cmp_q;

    // The generator updates on the strobe edge, so its new sample is
    // only safe to take one cycle later.
    target = bus.mute ? '0 : bus.volume;
    if (ena_d_q) begin
      sample_d  = bus.sample;
      vol_eff_d = gain_step(vol_eff_q, target);
    end

    level_d = LEVEL_W'(sample_q) * LEVEL_W'(vol_eff_q);

    pwm_cnt_d = (pwm_cnt_q == LEVEL_W'(PWM_PERIOD - 1)) ? '0 : pwm_cnt_q + LEVEL_W'(1);
    // Compare value only reloads at frame start to avoid mid-frame glitches.
    if (pwm_cnt_q == '0) begin
      pwm_cmp_d = level_q;
    end
    pwm_bit = (pwm_cnt_q < pwm_cmp_q);

    sd_sum   = {1'b0, sd_acc_q} + {1'b0, level_q};
    sd_acc_d = sd_sum[LEVEL_W-1:0];

    // Both modulators always run; mode only picks which one reaches the pin.
    audio_d = (mode_e'(bus.mode) == MODE_SD) ? sd_sum[LEVEL_W] : pwm_bit;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ena_d_q   <= 1'b0;
      sample_q  <= '0;
      vol_eff_q <= '0;
      level_q   <= '0;
      pwm_cnt_q <= '0;
      pwm_cmp_q <= '0;
      sd_acc_q  <= '0;
      audio_q   <= 1'b0;
    end else begin
      ena_d_q   <= ena_d_d;
      sample_q  <= sample_d;
      vol_eff_q <= vol_eff_d;
      level_q   <= level_d;
      pwm_cnt_q <= pwm_cnt_d;
      pwm_cmp_q <= pwm_cmp_d;
      sd_acc_q  <= sd_acc_d;
      audio_q   <= audio_d;
    end
  end

  assign bus.sample_ena = ena;
  assign bus.level      = level_q;
  assign bus.audio_out  = audio_q;

endmodule

// File: tb/tb_audio_out_dac.sv
module tb_audio_out_dac;
  localparam int CF = 100;
  localparam int SR = 30;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  audio_out_dac_if bus();

  audio_out_dac #(.CLK_FREQ(CF), .SAMPLE_RATE(SR)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state (spec-level quantities)
  longint m_k;      // non-reset edges since reset
  logic   m_ena, m_ena_d, m_audio;
  int     m_sample, m_gain, m_level, m_cmp, m_res;

  // Advance one clock and update the model from the inputs seen at that edge.
  task automatic step();
    longint k1;
    int c, r, tgt;
    logic pb, sb;
    @(posedge clock);
    if (reset) begin
      m_k = 0; m_ena = 0; m_ena_d = 0; m_audio = 0;
      m_sample = 0; m_gain = 0; m_level = 0; m_cmp = 0; m_res = 0;
    end else begin
      k1 = m_k + 1;
      c  = int'(m_k % 255);
      pb = (c < m_cmp);
      r  = m_res + m_level;
      sb = (r >= 256);
      m_audio = bus.mode ? sb : pb;
      m_res = r % 256;
      if (c == 0) m_cmp = m_level;
      m_level = m_sample * m_gain;
      if (m_ena_d) begin
        tgt = bus.mute ? 0 : int'(bus.volume);
        m_sample = int'(bus.sample);
        if (m_gain < tgt) m_gain++;
        else if (m_gain > tgt) m_gain--;
      end
      m_ena_d = m_ena;
      m_ena = ((k1 * SR) / CF) != ((m_k * SR) / CF);
      m_k = k1;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    n_checks++; if (bus.sample_ena !== 1'b0) begin n_fail++; $display("FAIL reset_ena got=%b want=0", bus.sample_ena); end
    n_checks++; if (bus.level !== 8'd0) begin n_fail++; $display("FAIL reset_level got=%0d want=0", bus.level); end
    n_checks++; if (bus.audio_out !== 1'b0) begin n_fail++; $display("FAIL reset_audio got=%b want=0", bus.audio_out); end
    reset = 1'b0;
  endtask

  task automatic test_divider();
    int first, cnt, adj;
    logic prev;
    first = -1; cnt = 0; adj = 0; prev = 0;
    for (int k = 1; k <= 100; k++) begin
      step();
      n_checks++;
      if (bus.sample_ena !== m_ena) begin n_fail++; $display("FAIL div_strobe k=%0d got=%b want=%b", k, bus.sample_ena, m_ena); end
      if (bus.sample_ena === 1'b1) begin
        if (first < 0) first = k;
        cnt++;
        if (prev) adj++;
      end
      prev = bus.sample_ena;
    end
    n_checks++; if (first != 4) begin n_fail++; $display("FAIL div_first got=%0d want=4", first); end
    n_checks++; if (cnt != 30) begin n_fail++; $display("FAIL div_count got=%0d want=30", cnt); end
    n_checks++; if (adj != 0) begin n_fail++; $display("FAIL div_adjacent got=%0d want=0", adj); end
  endtask

  task automatic test_fade_in();
    int prev, changes;
    bus.sample = 4'd15; bus.volume = 4'd15; bus.mute = 1'b0;
    prev = 0; changes = 0;
    for (int i = 0; i < 90; i++) begin
      step();
      n_checks++; if (bus.level !== 8'(m_level)) begin n_fail++; $display("FAIL fade_level got=%0d want=%0d", bus.level, m_level); end
      if (int'(bus.level) != prev) begin
        n_checks++;
        if (int'(bus.level) != prev + 15) begin n_fail++; $display("FAIL fade_step got=%0d want=%0d", bus.level, prev + 15); end
        changes++; prev = int'(bus.level);
      end
    end
    n_checks++; if (bus.level !== 8'd225) begin n_fail++; $display("FAIL fade_final got=%0d want=225", bus.level); end
    n_checks++; if (changes != 15) begin n_fail++; $display("FAIL fade_steps got=%0d want=15", changes); end
  endtask

  task automatic test_mute_retarget();
    int prev, changes, ones;
    bus.mute = 1'b1;
    prev = 225; changes = 0;
    for (int i = 0; i < 90; i++) begin
      step();
      n_checks++; if (bus.level !== 8'(m_level)) begin n_fail++; $display("FAIL mute_level got=%0d want=%0d", bus.level, m_level); end
      if (int'(bus.level) != prev) begin
        n_checks++;
        if (int'(bus.level) != prev - 15) begin n_fail++; $display("FAIL mute_step got=%0d want=%0d", bus.level, prev - 15); end
        changes++; prev = int'(bus.level);
      end
    end
    n_checks++; if (bus.level !== 8'd0) begin n_fail++; $display("FAIL mute_final got=%0d want=0", bus.level); end
    n_checks++; if (changes != 15) begin n_fail++; $display("FAIL mute_steps got=%0d want=15", changes); end
    for (int i = 0; i < 260; i++) step();
    ones = 0;
    bus.mode = 1'b0;
    for (int i = 0; i < 260; i++) begin step(); if (bus.audio_out !== 1'b0) ones++; end
    bus.mode = 1'b1;
    for (int i = 0; i < 60; i++) begin step(); if (bus.audio_out !== 1'b0) ones++; end
    n_checks++; if (ones != 0) begin n_fail++; $display("FAIL mute_silent got=%0d ones want=0", ones); end
    bus.mute = 1'b0; bus.volume = 4'd3;
    for (int i = 0; i < 40; i++) step();
    n_checks++; if (bus.level !== 8'd45) begin n_fail++; $display("FAIL retarget_start got=%0d want=45", bus.level); end
    bus.volume = 4'd8;
    prev = 45; changes = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (int'(bus.level) != prev) begin
        n_checks++;
        if (int'(bus.level) != prev + 15) begin n_fail++; $display("FAIL retarget_step got=%0d want=%0d", bus.level, prev + 15); end
        changes++; prev = int'(bus.level);
      end
    end
    n_checks++; if (changes != 5) begin n_fail++; $display("FAIL retarget_steps got=%0d want=5", changes); end
    n_checks++; if (bus.level !== 8'd120) begin n_fail++; $display("FAIL retarget_final got=%0d want=120", bus.level); end
  endtask

  task automatic test_sigma_delta();
    int ones, last_one, bad_gap;
    bus.mode = 1'b1;
    for (int i = 0; i < 10; i++) step();
    ones = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      n_checks++; if (bus.audio_out !== m_audio) begin n_fail++; $display("FAIL sd_bit got=%b want=%b", bus.audio_out, m_audio); end
      if (bus.audio_out === 1'b1) ones++;
    end
    n_checks++; if (ones != 120) begin n_fail++; $display("FAIL sd_density120 got=%0d want=120", ones); end
    bus.volume = 4'd15;
    for (int i = 0; i < 60; i++) step();
    ones = 0;
    for (int i = 0; i < 256; i++) begin step(); if (bus.audio_out === 1'b1) ones++; end
    n_checks++; if (ones != 225) begin n_fail++; $display("FAIL sd_density225 got=%0d want=225", ones); end
    bus.sample = 4'd8; bus.volume = 4'd8;
    for (int i = 0; i < 60; i++) step();
    n_checks++; if (bus.level !== 8'd64) begin n_fail++; $display("FAIL sd_level64 got=%0d want=64", bus.level); end
    ones = 0; last_one = -1; bad_gap = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      if (bus.audio_out === 1'b1) begin
        ones++;
        if (last_one >= 0 && i - last_one != 4) bad_gap++;
        last_one = i;
      end
    end
    n_checks++; if (ones != 64) begin n_fail++; $display("FAIL sd_density64 got=%0d want=64", ones); end
    n_checks++; if (bad_gap != 0) begin n_fail++; $display("FAIL sd_spacing64 got=%0d bad gaps want=0", bad_gap); end
  endtask

  task automatic test_pwm();
    int highs;
    bus.mode = 1'b0; bus.sample = 4'd10; bus.volume = 4'd10;
    for (int i = 0; i < 300; i++) step();
    for (int i = 0; i < 255 && (m_k % 255) != 0; i++) step();
    n_checks++; if ((m_k % 255) != 0) begin n_fail++; $display("FAIL pwm_align got=%0d want=0", m_k % 255); end
    for (int p = 0; p < 3; p++) begin
      highs = 0;
      for (int i = 0; i < 255; i++) begin
        if (p == 1 && i == 127) bus.sample = 4'd5;
        step();
        n_checks++; if (bus.audio_out !== m_audio) begin n_fail++; $display("FAIL pwm_bit p=%0d i=%0d got=%b want=%b", p, i, bus.audio_out, m_audio); end
        if (bus.audio_out === 1'b1) highs++;
        if (p == 0 && (i == 0 || i == 99 || i == 100)) begin
          n_checks++;
          if (bus.audio_out !== logic'(i < 100)) begin n_fail++; $display("FAIL pwm_edge i=%0d got=%b want=%b", i, bus.audio_out, i < 100); end
        end
      end
      n_checks++;
      if (highs != (p < 2 ? 100 : 50)) begin n_fail++; $display("FAIL pwm_period p=%0d got=%0d want=%0d", p, highs, (p < 2 ? 100 : 50)); end
    end
  endtask

  task automatic test_reset_mid_run();
    logic exp;
    bus.mode = 1'b1;
    for (int i = 0; i < 20; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++; if (bus.audio_out !== 1'b0) begin n_fail++; $display("FAIL rst_mid_audio got=%b want=0", bus.audio_out); end
    n_checks++; if (bus.level !== 8'd0) begin n_fail++; $display("FAIL rst_mid_level got=%0d want=0", bus.level); end
    n_checks++; if (bus.sample_ena !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ena got=%b want=0", bus.sample_ena); end
    for (int k = 1; k <= 30; k++) begin
      step();
      exp = (k % 10 == 0) || (k % 10 == 4) || (k % 10 == 7);
      n_checks++; if (bus.sample_ena !== exp) begin n_fail++; $display("FAIL rst_mid_strobe k=%0d got=%b want=%b", k, bus.sample_ena, exp); end
      if (k <= 5) begin
        n_checks++; if (bus.level !== 8'd0) begin n_fail++; $display("FAIL rst_mid_gain0 k=%0d got=%0d want=0", k, bus.level); end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      bus.sample = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) bus.volume = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) == 0) bus.mute = ~bus.mute;
      if ($urandom_range(0, 199) == 0) bus.mode = ~bus.mode;
      reset = ($urandom_range(0, 999) == 0);
      step();
      n_checks++; if (bus.sample_ena !== m_ena) begin n_fail++; $display("FAIL rnd_ena i=%0d got=%b want=%b", i, bus.sample_ena, m_ena); end
      n_checks++; if (bus.level !== 8'(m_level)) begin n_fail++; $display("FAIL rnd_level i=%0d got=%0d want=%0d", i, bus.level, m_level); end
      n_checks++; if (bus.audio_out !== m_audio) begin n_fail++; $display("FAIL rnd_audio i=%0d got=%b want=%b", i, bus.audio_out, m_audio); end
    end
    reset = 1'b0;
  endtask

  initial begin
    bus.sample = '0; bus.volume = '0; bus.mute = 1'b0; bus.mode = 1'b0;
    m_k = 0; m_ena = 0; m_ena_d = 0; m_audio = 0;
    m_sample = 0; m_gain = 0; m_level = 0; m_cmp = 0; m_res = 0;
    #1;
    test_reset();
    test_divider();
    test_fade_in();
    test_mute_retarget();
    test_sigma_delta();
    test_pwm();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
